// File: rtl/rfile_wb_ctrl_if.sv
// Bundle of the writeback-controller signals: ALU and load writeback sources,
// decode hazard query, and the register file write port.
interface rfile_wb_ctrl_if #(
   parameter int DATA_W = 16,
   parameter int REG_W  = 3
);
   logic              alu_valid;
   logic [REG_W-1:0]  alu_adr;
   logic [DATA_W-1:0] alu_data;
   logic              alu_ready;
   logic              ld_issue;
   logic [REG_W-1:0]  ld_issue_adr;
   logic              ld_valid;
   logic [REG_W-1:0]  ld_adr;
   logic [DATA_W-1:0] ld_data;
   logic [REG_W-1:0]  aadr;
   logic [REG_W-1:0]  badr;
   logic [REG_W-1:0]  dadr;
   logic              hazard;
   logic [REG_W-1:0]  cadr;
   logic [DATA_W-1:0] c;
   logic              we;
   logic              err;

   modport slave (
      input  alu_valid, alu_adr, alu_data,
      input  ld_issue, ld_issue_adr, ld_valid, ld_adr, ld_data,
      input  aadr, badr, dadr,
      output alu_ready, hazard, cadr, c, we, err
   );

   modport master (
      output alu_valid, alu_adr, alu_data,
      output ld_issue, ld_issue_adr, ld_valid, ld_adr, ld_data,
      output aadr, badr, dadr,
      input  alu_ready, hazard, cadr, c, we, err
   );
endinterface

// File: rtl/rfile_wb_ctrl.sv
// Register file write-port arbiter (loads over ALU, one-entry ALU skid buffer)
// with a pending-load scoreboard that drives the decode hazard.
module rfile_wb_ctrl #(
   parameter int DATA_W = 16,
   parameter int REG_W  = 3
) (
   input logic           clk,
   input logic           rst,
   rfile_wb_ctrl_if.slave bus
);
   localparam int N_REG = 2**REG_W;

   logic              r_buf_valid;
   logic [REG_W-1:0]  r_buf_adr;
   logic [DATA_W-1:0] r_buf_data;
   logic              r_we;
   logic [REG_W-1:0]  r_cadr;
   logic [DATA_W-1:0] r_c;
   logic              r_err;
   logic [N_REG-1:0]  r_pending;

   logic              w_alu_fire;
   logic [N_REG-1:0]  w_set;
   logic [N_REG-1:0]  w_clr;
   logic              w_err_issue;
   logic              w_err_ld;
   logic              w_err_alu;
   logic              w_port_match;

   assign w_alu_fire = bus.alu_valid & ~r_buf_valid;

   for (genvar gi = 0; gi < N_REG; gi++) begin : g_sb
      assign w_set[gi] = bus.ld_issue & (bus.ld_issue_adr == REG_W'(gi));
      assign w_clr[gi] = bus.ld_valid & (bus.ld_adr == REG_W'(gi));
   end

   // A same-cycle clear of the issued register makes the reissue legal.
   assign w_err_issue = bus.ld_issue & r_pending[bus.ld_issue_adr]
                      & ~(bus.ld_valid & (bus.ld_adr == bus.ld_issue_adr));
   assign w_err_ld    = bus.ld_valid & ~r_pending[bus.ld_adr];
   assign w_err_alu   = bus.alu_valid & r_pending[bus.alu_adr];

   // The register file reads the old value while the write is on the port.
   assign w_port_match = r_we & ((r_cadr == bus.aadr) | (r_cadr == bus.badr)
                                 | (r_cadr == bus.dadr));

   assign bus.hazard    = r_pending[bus.aadr] | r_pending[bus.badr]
                        | r_pending[bus.dadr] | w_port_match;
   assign bus.alu_ready = ~r_buf_valid;
   assign bus.we        = r_we;
   assign bus.cadr      = r_cadr;
   assign bus.c         = r_c;
   assign bus.err       = r_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pending <= '0;
         r_err     <= 1'b0;
      end else begin
         r_pending <= (r_pending & ~w_clr) | w_set;
         if (w_err_issue | w_err_ld | w_err_alu)
            r_err <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_buf_valid <= 1'b0;
         r_buf_adr   <= '0;
         r_buf_data  <= '0;
         r_we        <= 1'b0;
         r_cadr      <= '0;
         r_c         <= '0;
      end else if (bus.ld_valid) begin
         r_we   <= 1'b1;
         r_cadr <= bus.ld_adr;
         r_c    <= bus.ld_data;
         if (w_alu_fire) begin
            r_buf_valid <= 1'b1;
            r_buf_adr   <= bus.alu_adr;
            r_buf_data  <= bus.alu_data;
         end
      end else if (r_buf_valid) begin
         r_we        <= 1'b1;
         r_cadr      <= r_buf_adr;
         r_c         <= r_buf_data;
         r_buf_valid <= 1'b0;
      end else if (bus.alu_valid) begin
         r_we   <= 1'b1;
         r_cadr <= bus.alu_adr;
         r_c    <= bus.alu_data;
      end else begin
         r_we <= 1'b0;
      end
   end
endmodule

// File: tb/tb_rfile_wb_ctrl.sv
// Directed-vector bench for rfile_wb_ctrl; outputs sampled 1 time unit after
// the rising edge, expected values hand-computed.
module tb_rfile_wb_ctrl;
   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;

   rfile_wb_ctrl_if #(.DATA_W(16), .REG_W(3)) bus ();

   rfile_wb_ctrl #(.DATA_W(16), .REG_W(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end else begin
         $display("ok   %s: %0h", tag, obs);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.alu_valid    = 1'b0;
      bus.ld_issue     = 1'b0;
      bus.ld_valid     = 1'b0;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst = 1'b1;
      idle();
      bus.alu_adr = '0;  bus.alu_data = '0;
      bus.ld_issue_adr = '0;
      bus.ld_adr = '0;   bus.ld_data = '0;
      bus.aadr = '0; bus.badr = '0; bus.dadr = '0;

      // Reset with ALU offering a result
      bus.alu_valid = 1'b1; bus.alu_adr = 3'd3; bus.alu_data = 16'h1234;
      tick(); tick();
      chk("rst_we", bus.we, 0);
      chk("rst_ready", bus.alu_ready, 1);
      chk("rst_hazard", bus.hazard, 0);
      chk("rst_err", bus.err, 0);
      chk("rst_cadr", bus.cadr, 0);
      chk("rst_c", bus.c, 0);
      rst = 1'b0;
      tick();
      chk("alu_we", bus.we, 1);
      chk("alu_cadr", bus.cadr, 3);
      chk("alu_c", bus.c, 16'h1234);
      idle();
      tick();
      chk("idle_we", bus.we, 0);
      chk("idle_c_hold", bus.c, 16'h1234);

      // Load and ALU collide: load wins, ALU goes to skid buffer
      bus.ld_issue = 1'b1; bus.ld_issue_adr = 3'd5;
      tick();
      idle();
      bus.ld_valid = 1'b1; bus.ld_adr = 3'd5; bus.ld_data = 16'hBEEF;
      bus.alu_valid = 1'b1; bus.alu_adr = 3'd2; bus.alu_data = 16'h0042;
      tick();
      idle();
      chk("col_ld_we", bus.we, 1);
      chk("col_ld_cadr", bus.cadr, 5);
      chk("col_ld_c", bus.c, 16'hBEEF);
      chk("col_ready0", bus.alu_ready, 0);
      tick();
      chk("col_alu_cadr", bus.cadr, 2);
      chk("col_alu_c", bus.c, 16'h0042);
      chk("col_ready1", bus.alu_ready, 1);
      chk("col_err", bus.err, 0);

      // Hazard on pending load and through the write-port cycle
      bus.ld_issue = 1'b1; bus.ld_issue_adr = 3'd6; bus.aadr = 3'd6;
      #1 chk("hz_same_cycle", bus.hazard, 0);
      tick();
      idle();
      chk("hz_set", bus.hazard, 1);
      tick();
      chk("hz_hold", bus.hazard, 1);
      bus.ld_valid = 1'b1; bus.ld_adr = 3'd6; bus.ld_data = 16'h0606;
      tick();
      idle();
      chk("hz_we_cycle_we", bus.we, 1);
      chk("hz_we_cycle", bus.hazard, 1);
      tick();
      chk("hz_drop", bus.hazard, 0);
      bus.aadr = 3'd0;

      // Three back-to-back loads starve a buffered ALU result
      bus.ld_issue = 1'b1; bus.ld_issue_adr = 3'd1; tick();
      bus.ld_issue_adr = 3'd3; tick();
      bus.ld_issue_adr = 3'd7; tick();
      idle();
      bus.ld_valid = 1'b1; bus.ld_adr = 3'd1; bus.ld_data = 16'h1111;
      bus.alu_valid = 1'b1; bus.alu_adr = 3'd4; bus.alu_data = 16'h4444;
      tick();
      chk("st1_cadr", bus.cadr, 1);
      chk("st1_ready", bus.alu_ready, 0);
      bus.ld_adr = 3'd3; bus.ld_data = 16'h3333;
      bus.alu_adr = 3'd0; bus.alu_data = 16'h0A0A;
      tick();
      chk("st2_cadr", bus.cadr, 3);
      chk("st2_ready", bus.alu_ready, 0);
      bus.ld_adr = 3'd7; bus.ld_data = 16'h7777;
      tick();
      chk("st3_cadr", bus.cadr, 7);
      chk("st3_ready", bus.alu_ready, 0);
      bus.ld_valid = 1'b0;
      tick();
      chk("st_drain_cadr", bus.cadr, 4);
      chk("st_drain_c", bus.c, 16'h4444);
      chk("st_drain_ready", bus.alu_ready, 1);
      tick();
      idle();
      chk("st_held_cadr", bus.cadr, 0);
      chk("st_held_c", bus.c, 16'h0A0A);
      chk("st_err", bus.err, 0);

      // Reissue and return on the same register in one cycle
      bus.ld_issue = 1'b1; bus.ld_issue_adr = 3'd4; tick();
      bus.ld_valid = 1'b1; bus.ld_adr = 3'd4; bus.ld_data = 16'h4040;
      bus.dadr = 3'd4;
      tick();
      idle();
      chk("ri_cadr", bus.cadr, 4);
      chk("ri_c", bus.c, 16'h4040);
      chk("ri_err", bus.err, 0);
      tick();
      chk("ri_pending", bus.hazard, 1);
      bus.ld_valid = 1'b1; tick(); idle(); tick();
      chk("ri_cleared", bus.hazard, 0);
      bus.dadr = 3'd0;

      // Load return to a non-pending register
      bus.ld_valid = 1'b1; bus.ld_adr = 3'd1; bus.ld_data = 16'h0111;
      tick();
      idle();
      chk("np_err", bus.err, 1);
      chk("np_cadr", bus.cadr, 1);
      chk("np_c", bus.c, 16'h0111);
      tick(); tick();
      chk("np_sticky", bus.err, 1);

      // Reset mid-operation drops pending bits and the buffered result
      bus.ld_issue = 1'b1; bus.ld_issue_adr = 3'd2; tick();
      idle();
      bus.ld_valid = 1'b1; bus.ld_adr = 3'd2;
      bus.alu_valid = 1'b1; bus.alu_adr = 3'd6; tick();
      idle();
      bus.badr = 3'd2;
      rst = 1'b1; #1;
      chk("mid_rst_err", bus.err, 0);
      chk("mid_rst_ready", bus.alu_ready, 1);
      bus.ld_issue = 1'b1; bus.ld_issue_adr = 3'd2;
      tick();
      rst = 1'b0; idle();
      chk("mid_rst_hazard", bus.hazard, 0);
      tick();
      chk("mid_rst_we", bus.we, 0);

      // ALU write to a pending register
      bus.ld_issue = 1'b1; bus.ld_issue_adr = 3'd5; tick();
      idle();
      bus.alu_valid = 1'b1; bus.alu_adr = 3'd5; bus.alu_data = 16'h5555;
      tick();
      idle();
      chk("alu_pend_err", bus.err, 1);
      chk("alu_pend_c", bus.c, 16'h5555);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
